memref_copy_engine: RTL and testbench

Initiator side of the memref read/write port protocol: streams `len` words out of a source memory through a read port (`rd_en`/`addr` in, `dout_valid`/`dout` back one cycle later) and into a destination memory through a write port (`wr_en`/`addr`/`din`). It sits between two memory models, or two HIR memref ports, and is used as the simplest self-checking consumer/producer of those ports in benches and as a bulk-copy helper in generated designs. A run starts on a one-cycle `start` pulse and finishes with a one-cycle `done` pulse.

---
 rtl/memref_pkg.sv | 28 ++
 rtl/memref_addr_ctr.sv | 36 +++
 rtl/memref_copy_engine.sv | 144 ++++++++++++++
 tb/tb_memref_copy_engine.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/memref_pkg.sv
`default_nettype none
// ============================================================================
// memref_pkg : shared state encoding and length/address helpers for the copy engine
// Revision   : 1.0
// ============================================================================
package memref_pkg;

    localparam int unsigned DEFAULT_WIDTH = 32;
    localparam int unsigned DEFAULT_SIZE  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } memref_state_e;

    // AW = $clog2(SIZE)
    function automatic int unsigned addr_width(input int unsigned size);
        return $clog2(size);
    endfunction

    function automatic int unsigned clamp_len(input int unsigned len, input int unsigned size);
        return (len > size) ? size : len;
    endfunction

endpackage
`default_nettype wire

// File: rtl/memref_addr_ctr.sv
`default_nettype none
// ============================================================================
// memref_addr_ctr : loadable address counter that wraps modulo SIZE
// Revision        : 1.0
// ============================================================================
module memref_addr_ctr #(
    parameter int SIZE = 8,
    parameter int AW   = $clog2(SIZE)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_load,
    input  logic [AW-1:0] i_load_val,
    input  logic          i_inc,
    output logic [AW-1:0] o_count
);

    // Explicit wrap so non-power-of-two sizes skip the unused codes
    localparam logic [AW-1:0] c_LAST_ADDR = AW'(SIZE - 1);

    logic [AW-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_inc) begin
            r_count <= (r_count == c_LAST_ADDR) ? '0 : r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/memref_copy_engine.sv
`default_nettype none
// ============================================================================
// memref_copy_engine : streams len words from a read port into a write port
// Revision           : 1.0
// ============================================================================
module memref_copy_engine
    import memref_pkg::*;
#(
    parameter  int WIDTH = DEFAULT_WIDTH,
    parameter  int SIZE  = DEFAULT_SIZE,
    localparam int AW    = addr_width(SIZE)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [AW-1:0]    src_base,
    input  logic [AW-1:0]    dst_base,
    input  logic [AW:0]      len,
    output logic             busy,
    output logic             done,
    output logic             rd_en,
    output logic [AW-1:0]    rd_addr,
    input  logic             dout_valid,
    input  logic [WIDTH-1:0] dout,
    output logic             wr_en,
    output logic [AW-1:0]    wr_addr,
    output logic [WIDTH-1:0] din
);

    memref_state_e    r_state;
    logic             r_busy;
    logic             r_done;
    logic             r_rd_en;
    logic             r_wr_en;
    logic [AW-1:0]    r_wr_addr;
    logic [WIDTH-1:0] r_din;
    logic [AW:0]      r_len;
    logic [AW:0]      r_rd_cnt;
    logic [AW:0]      r_wr_cnt;

    logic [AW:0]      w_len_clamped;
    logic [AW-1:0]    w_rd_addr;
    logic [AW-1:0]    w_wr_ptr;
    logic             w_start_ok;
    logic             w_rd_adv;
    logic             w_capture;

    assign w_len_clamped = (AW+1)'(clamp_len(32'(len), SIZE));
    assign w_start_ok    = (r_state == IDLE) && start;
    // r_rd_cnt counts the read currently on the port, so stop advancing on the last one
    assign w_rd_adv      = (r_state == RUN) && (r_rd_cnt != r_len);
    assign w_capture     = dout_valid && ((r_state == RUN) || (r_state == DRAIN));

    memref_addr_ctr #(.SIZE(SIZE), .AW(AW)) u_rd_ctr (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_start_ok),
        .i_load_val (src_base),
        .i_inc      (w_rd_adv),
        .o_count    (w_rd_addr)
    );

    memref_addr_ctr #(.SIZE(SIZE), .AW(AW)) u_wr_ctr (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_start_ok),
        .i_load_val (dst_base),
        .i_inc      (w_capture),
        .o_count    (w_wr_ptr)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_rd_en   <= 1'b0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_din     <= '0;
            r_len     <= '0;
            r_rd_cnt  <= '0;
            r_wr_cnt  <= '0;
        end else begin
            r_wr_en <= w_capture;
            if (w_capture) begin
                r_din     <= dout;
                r_wr_addr <= w_wr_ptr;
                r_wr_cnt  <= r_wr_cnt + 1'b1;
            end

            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_len    <= w_len_clamped;
                        r_wr_cnt <= '0;
                        r_busy   <= 1'b1;
                        if (w_len_clamped == '0) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state  <= RUN;
                            r_rd_en  <= 1'b1;
                            r_rd_cnt <= (AW+1)'(1);
                        end
                    end
                end
                RUN: begin
                    if (r_rd_cnt == r_len) begin
                        r_rd_en <= 1'b0;
                        r_state <= DRAIN;
                    end else begin
                        r_rd_cnt <= r_rd_cnt + 1'b1;
                    end
                end
                DRAIN: begin
                    if (r_wr_cnt == r_len) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign rd_en   = r_rd_en;
    assign rd_addr = w_rd_addr;
    assign wr_en   = r_wr_en;
    assign wr_addr = r_wr_addr;
    assign din     = r_din;

endmodule
`default_nettype wire

// File: tb/tb_memref_copy_engine.sv
`default_nettype none
// ============================================================================
// tb_memref_copy_engine : directed and random copies against a memory-level model
// Revision              : 1.0
// ============================================================================
module tb_memref_copy_engine;

    localparam int WIDTH = 32;
    localparam int SIZE  = 8;
    localparam int AW    = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [AW-1:0]    src_base = '0;
    logic [AW-1:0]    dst_base = '0;
    logic [AW:0]      len = '0;
    logic             busy, done, rd_en, wr_en, dout_valid;
    logic [AW-1:0]    rd_addr, wr_addr;
    logic [WIDTH-1:0] dout, din;
    logic             stray = 1'b0;

    logic [WIDTH-1:0] src_mem [SIZE];
    logic [WIDTH-1:0] dst_mem [SIZE];
    logic [WIDTH-1:0] exp_dst [SIZE];

    int tests = 0;
    int fails = 0;
    int pc = 0;
    int s0 = 0;
    int busy_n = 0;
    int rd_cyc[$];
    int rd_adr[$];
    int wr_cyc[$];
    int wr_adr[$];
    int done_cyc[$];
    logic [WIDTH-1:0] wr_dat[$];

    memref_copy_engine #(.WIDTH(WIDTH), .SIZE(SIZE)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .src_base   (src_base),
        .dst_base   (dst_base),
        .len        (len),
        .busy       (busy),
        .done       (done),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .dout_valid (dout_valid),
        .dout       (dout),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .din        (din)
    );

    always #5 clk = ~clk;

    // Source and destination memory models on the two ports
    always @(posedge clk) begin
        pc         <= pc + 1;
        dout_valid <= rd_en | stray;
        dout       <= stray ? WIDTH'($urandom) : src_mem[rd_addr];
        if (wr_en) dst_mem[wr_addr] = din;
    end

    always @(negedge clk) begin
        if (rd_en) begin
            rd_cyc.push_back(pc - s0);
            rd_adr.push_back(int'(rd_addr));
        end
        if (wr_en) begin
            wr_cyc.push_back(pc - s0);
            wr_adr.push_back(int'(wr_addr));
            wr_dat.push_back(din);
        end
        if (done) done_cyc.push_back(pc - s0);
        if (busy) busy_n++;
    end

    task automatic chk(input string tag, input longint obs, input longint exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        rd_cyc.delete(); rd_adr.delete();
        wr_cyc.delete(); wr_adr.delete(); wr_dat.delete();
        done_cyc.delete();
        busy_n = 0;
    endtask

    task automatic check_dst();
        for (int j = 0; j < SIZE; j++) chk($sformatf("dst[%0d]", j), dst_mem[j], exp_dst[j]);
    endtask

    task automatic do_run(input int sb, input int db, input int ln, input bit inj);
        int n, lat;
        n   = (ln > SIZE) ? SIZE : ln;
        lat = (n == 0) ? 1 : n + 3;
        @(negedge clk);
        clear_mon();
        s0 = pc;
        start = 1'b1; src_base = AW'(sb); dst_base = AW'(db); len = (AW+1)'(ln);
        @(negedge clk);
        start = 1'b0;
        for (int k = 2; k < 40 && done_cyc.size() == 0; k++) begin
            @(negedge clk);
            if (inj && k == 2) begin
                start = 1'b1; src_base = AW'(sb + 3); dst_base = AW'(db + 1); len = 4'd2;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < n; i++) exp_dst[(db + i) % SIZE] = src_mem[(sb + i) % SIZE];

        chk("rd_count", rd_cyc.size(), n);
        for (int i = 0; i < rd_cyc.size() && i < n; i++) begin
            chk("rd_cycle", rd_cyc[i], 1 + i);
            chk("rd_addr", rd_adr[i], (sb + i) % SIZE);
        end
        chk("wr_count", wr_cyc.size(), n);
        for (int i = 0; i < wr_cyc.size() && i < n; i++) begin
            chk("wr_cycle", wr_cyc[i], 3 + i);
            chk("wr_addr", wr_adr[i], (db + i) % SIZE);
            chk("wr_data", wr_dat[i], src_mem[(sb + i) % SIZE]);
        end
        chk("done_count", done_cyc.size(), 1);
        if (done_cyc.size() > 0) chk("done_cycle", done_cyc[0], lat);
        chk("busy_cycles", busy_n, lat);
        check_dst();
    endtask

    initial begin
        for (int i = 0; i < SIZE; i++) begin
            src_mem[i] = WIDTH'(10 + i);
            dst_mem[i] = '0;
            exp_dst[i] = '0;
        end

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rd_en", rd_en, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_rd_addr", rd_addr, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_din", din, 0);
        rst = 1'b0;

        do_run(2, 5, 3, 1'b0);   // basic copy
        do_run(6, 7, 4, 1'b0);   // address wrap
        do_run(3, 3, 0, 1'b0);   // zero length
        do_run(1, 2, 12, 1'b0);  // clamp to SIZE
        do_run(0, 3, 4, 1'b1);   // start while busy

        // Reset in cycle 3 of a len=6 run
        @(negedge clk);
        clear_mon();
        s0 = pc;
        start = 1'b1; src_base = 3'd1; dst_base = 3'd4; len = 4'd6;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk); rst = 1'b1;
        exp_dst[4] = src_mem[1];
        for (int k = 4; k < 8; k++) begin
            @(negedge clk);
            if (k == 5) rst = 1'b0;
            chk("abort_rd_en", rd_en, 0);
            chk("abort_wr_en", wr_en, 0);
            chk("abort_busy", busy, 0);
            chk("abort_done", done, 0);
        end
        chk("abort_done_count", done_cyc.size(), 0);
        chk("abort_rd_count", rd_cyc.size(), 3);
        chk("abort_wr_count", wr_cyc.size(), 1);
        do_run(5, 6, 2, 1'b0);

        // Stray read data while idle
        @(negedge clk);
        clear_mon();
        stray = 1'b1;
        repeat (3) @(negedge clk);
        stray = 1'b0;
        repeat (3) @(negedge clk);
        chk("stray_wr_count", wr_cyc.size(), 0);
        chk("stray_busy", busy_n, 0);
        check_dst();

        // Random contents and transfers
        for (int i = 0; i < SIZE; i++) src_mem[i] = WIDTH'($urandom);
        for (int r = 0; r < 8; r++) begin
            do_run(int'($urandom_range(0, SIZE - 1)), int'($urandom_range(0, SIZE - 1)),
                   int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
